// File: rtl/as_quote_pkg.sv
// Shared types and fixed-point helpers for the Avellaneda-Stoikov quote pipeline.
// All fixed-point values are Q32.32; the wide signed type carries the reservation arithmetic.
package as_quote_pkg;

    localparam int FRAC_BITS = 32;
    localparam int LATENCY   = 5;
    localparam int WIDE_BITS = 98;

    typedef logic [63:0] q32_32_t;
    typedef logic signed [WIDE_BITS-1:0] wide_t;

    // Q64.64 product narrowed back to Q32.32; any integer overflow pins to all-ones.
    function automatic q32_32_t q_mul_sat(input q32_32_t a, input q32_32_t b);
        logic [127:0] prod;
        prod = {64'd0, a} * {64'd0, b};
        if ((prod >> 96) != 128'd0) begin
            return '1;
        end
        return q32_32_t'(prod >> FRAC_BITS);
    endfunction

    function automatic logic [31:0] clamp_u32(input wide_t v);
        if (v < 0) begin
            return 32'd0;
        end
        if (v > wide_t'(33'h0_FFFF_FFFF)) begin
            return '1;
        end
        return 32'(v);
    endfunction

endpackage

// File: rtl/as_quote_pipeline_if.sv
// Sample-in / quote-out bundle between the volatility stage, the quote pipeline and its consumer.
interface as_quote_pipeline_if #(
    parameter int NUM_STOCKS   = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int FP_WORD_SIZE = 64
);
    localparam int SID_W = $clog2(NUM_STOCKS);

    logic                    i_data_valid;
    logic [FP_WORD_SIZE-1:0] i_volatility;
    logic [DATA_WIDTH-1:0]   i_curr_price;
    logic [SID_W-1:0]        i_stock_id;

    logic                    o_quote_valid;
    logic [SID_W-1:0]        o_stock_id;
    logic [DATA_WIDTH-1:0]   o_bid_price;
    logic [DATA_WIDTH-1:0]   o_ask_price;
    logic [FP_WORD_SIZE-1:0] o_reservation;

    modport master (
        output i_data_valid, i_volatility, i_curr_price, i_stock_id,
        input  o_quote_valid, o_stock_id, o_bid_price, o_ask_price, o_reservation
    );

    modport slave (
        input  i_data_valid, i_volatility, i_curr_price, i_stock_id,
        output o_quote_valid, o_stock_id, o_bid_price, o_ask_price, o_reservation
    );

endinterface

// File: rtl/as_inventory_regfile.sv
// Per-stock signed inventory store: synchronous write, asynchronous read.
// A same-cycle write to the entry being read is forwarded straight to the reader.
module as_inventory_regfile #(
    parameter int NUM_STOCKS = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_wr_en,
    input  logic [$clog2(NUM_STOCKS)-1:0] i_wr_stock,
    input  logic signed [DATA_WIDTH-1:0]  i_wr_value,
    input  logic [$clog2(NUM_STOCKS)-1:0] i_rd_stock,
    output logic signed [DATA_WIDTH-1:0]  o_rd_value
);

    logic signed [DATA_WIDTH-1:0] inv_mem [NUM_STOCKS];

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            for (int i = 0; i < NUM_STOCKS; i++) begin
                inv_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            inv_mem[i_wr_stock] <= i_wr_value;
        end
    end

    assign o_rd_value = (i_wr_en && (i_wr_stock == i_rd_stock)) ? i_wr_value : inv_mem[i_rd_stock];

endmodule

// File: rtl/as_quote_pipeline.sv
// Avellaneda-Stoikov quoting: {sigma^2, mid price, stock} -> bid/ask/reservation,
// one quote per cycle, five register stages after sample capture, no backpressure.
module as_quote_pipeline
    import as_quote_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int FP_WORD_SIZE = 64,
    parameter int NUM_STOCKS   = 4
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    as_quote_pipeline_if.slave            quote_bus,
    input  logic [FP_WORD_SIZE-1:0]       i_gamma,
    input  logic [FP_WORD_SIZE-1:0]       i_time_remaining,
    input  logic [FP_WORD_SIZE-1:0]       i_spread_const,
    input  logic                          i_inv_wr_en,
    input  logic [$clog2(NUM_STOCKS)-1:0] i_inv_wr_stock,
    input  logic signed [DATA_WIDTH-1:0]  i_inv_wr_value
);

    localparam int SID_W = $clog2(NUM_STOCKS);
    localparam wide_t FRAC_ONES = wide_t'(64'h0000_0000_FFFF_FFFF);
    localparam wide_t RES_MAX   = wide_t'(64'h7FFF_FFFF_FFFF_FFFF);
    localparam wide_t RES_MIN   = -(wide_t'(64'h8000_0000_0000_0000));

    logic signed [DATA_WIDTH-1:0] inv_q;

    logic                         s1_valid, s2_valid, s3_valid, s4_valid, s5_valid;
    logic [SID_W-1:0]             s1_sid, s2_sid, s3_sid, s4_sid, s5_sid;
    logic [DATA_WIDTH-1:0]        s1_price, s2_price, s3_price, s4_price;
    logic signed [DATA_WIDTH-1:0] s1_q, s2_q, s3_q;
    q32_32_t                      s1_sigma2, s1_gamma, s1_tau, s2_tau;
    q32_32_t                      s1_spread, s2_spread, s3_spread;
    q32_32_t                      s2_a, s3_risk, s4_half;
    wide_t                        s4_skew, s5_r, s5_bid, s5_ask;
    wide_t                        r_c, bid_fp_c, ask_fp_c;
    logic [DATA_WIDTH-1:0]        bid_c, ask_c;
    q32_32_t                      res_c;

    as_inventory_regfile #(
        .NUM_STOCKS (NUM_STOCKS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_inventory (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_wr_en    (i_inv_wr_en),
        .i_wr_stock (i_inv_wr_stock),
        .i_wr_value (i_inv_wr_value),
        .i_rd_stock (quote_bus.i_stock_id),
        .o_rd_value (inv_q)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            s4_valid <= 1'b0;
            s5_valid <= 1'b0;
        end else begin
            s1_valid <= quote_bus.i_data_valid;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
            s4_valid <= s3_valid;
            s5_valid <= s4_valid;
        end
    end

    // Payload registers carry no reset: they are only observed through the valid chain.
    always_ff @(posedge i_clk) begin
        s1_sid    <= quote_bus.i_stock_id;
        s1_price  <= quote_bus.i_curr_price;
        s1_sigma2 <= quote_bus.i_volatility;
        s1_q      <= inv_q;
        s1_gamma  <= i_gamma;
        s1_tau    <= i_time_remaining;
        s1_spread <= i_spread_const;

        s2_sid    <= s1_sid;
        s2_price  <= s1_price;
        s2_q      <= s1_q;
        s2_tau    <= s1_tau;
        s2_spread <= s1_spread;
        s2_a      <= q_mul_sat(s1_gamma, s1_sigma2);

        s3_sid    <= s2_sid;
        s3_price  <= s2_price;
        s3_q      <= s2_q;
        s3_spread <= s2_spread;
        s3_risk   <= q_mul_sat(s2_a, s2_tau);

        s4_sid    <= s3_sid;
        s4_price  <= s3_price;
        s4_skew   <= wide_t'(s3_q) * wide_t'(s3_risk);
        s4_half   <= q32_32_t'(({1'b0, s3_risk} + {1'b0, s3_spread}) >> 1);

        s5_sid    <= s4_sid;
        s5_r      <= r_c;
        s5_bid    <= bid_fp_c >>> FRAC_BITS;
        s5_ask    <= (ask_fp_c + FRAC_ONES) >>> FRAC_BITS;
    end

    always_comb begin
        r_c      = wide_t'({s4_price, 32'd0}) - s4_skew;
        bid_fp_c = r_c - wide_t'(s4_half);
        ask_fp_c = r_c + wide_t'(s4_half);
    end

    // A one-tick spread is always kept; a bid pinned at the top pulls down instead of pushing ask over.
    always_comb begin
        bid_c = clamp_u32(s5_bid);
        ask_c = clamp_u32(s5_ask);
        if (ask_c == '0) begin
            ask_c = 32'd1;
        end
        if (bid_c >= ask_c) begin
            if (bid_c == '1) begin
                bid_c = ask_c - 32'd1;
            end else begin
                ask_c = bid_c + 32'd1;
            end
        end
        if (s5_r > RES_MAX) begin
            res_c = 64'h7FFF_FFFF_FFFF_FFFF;
        end else if (s5_r < RES_MIN) begin
            res_c = 64'h8000_0000_0000_0000;
        end else begin
            res_c = 64'(s5_r);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            quote_bus.o_quote_valid <= 1'b0;
            quote_bus.o_stock_id    <= '0;
            quote_bus.o_bid_price   <= '0;
            quote_bus.o_ask_price   <= '0;
            quote_bus.o_reservation <= '0;
        end else begin
            quote_bus.o_quote_valid <= s5_valid;
            if (s5_valid) begin
                quote_bus.o_stock_id    <= s5_sid;
                quote_bus.o_bid_price   <= bid_c;
                quote_bus.o_ask_price   <= ask_c;
                quote_bus.o_reservation <= res_c;
            end
        end
    end

endmodule

// File: tb/tb_as_quote_pipeline.sv
// Directed bench for as_quote_pipeline: hand-computed quotes for nominal, skew,
// rounding, clamp, bypass/interleave and mid-flight reset scenarios.
module tb_as_quote_pipeline;
    import as_quote_pkg::*;

    localparam int NUM_STOCKS = 4;
    localparam int SID_W      = $clog2(NUM_STOCKS);

    localparam logic [63:0] Q_0_25 = 64'h0000_0000_4000_0000;
    localparam logic [63:0] Q_0_5  = 64'h0000_0000_8000_0000;
    localparam logic [63:0] Q_1    = 64'h0000_0001_0000_0000;
    localparam logic [63:0] Q_2    = 64'h0000_0002_0000_0000;
    localparam logic [63:0] Q_4    = 64'h0000_0004_0000_0000;

    logic              clk;
    logic              reset_n;
    logic [63:0]       gamma;
    logic [63:0]       tau;
    logic [63:0]       spread_const;
    logic              inv_wr_en;
    logic [SID_W-1:0]  inv_wr_stock;
    logic signed [31:0] inv_wr_value;

    int check_count = 0;
    int error_count = 0;

    as_quote_pipeline_if #(.NUM_STOCKS(NUM_STOCKS), .DATA_WIDTH(32), .FP_WORD_SIZE(64)) quote_bus ();

    as_quote_pipeline #(
        .DATA_WIDTH   (32),
        .FP_WORD_SIZE (64),
        .NUM_STOCKS   (NUM_STOCKS)
    ) dut (
        .i_clk            (clk),
        .i_reset_n        (reset_n),
        .quote_bus        (quote_bus),
        .i_gamma          (gamma),
        .i_time_remaining (tau),
        .i_spread_const   (spread_const),
        .i_inv_wr_en      (inv_wr_en),
        .i_inv_wr_stock   (inv_wr_stock),
        .i_inv_wr_value   (inv_wr_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic setParams(input logic [63:0] g, input logic [63:0] t, input logic [63:0] sc);
        gamma        = g;
        tau          = t;
        spread_const = sc;
    endtask

    task automatic writeInventory(input logic [SID_W-1:0] sid, input logic signed [31:0] value);
        @(negedge clk);
        inv_wr_en    = 1'b1;
        inv_wr_stock = sid;
        inv_wr_value = value;
        @(negedge clk);
        inv_wr_en    = 1'b0;
    endtask

    task automatic applyStimulus(input logic [SID_W-1:0] sid, input logic [31:0] price, input logic [63:0] sigma2);
        @(negedge clk);
        quote_bus.i_data_valid = 1'b1;
        quote_bus.i_stock_id   = sid;
        quote_bus.i_curr_price = price;
        quote_bus.i_volatility = sigma2;
        @(negedge clk);
        quote_bus.i_data_valid = 1'b0;
    endtask

    // Must be called right after applyStimulus; the quote is due LATENCY negedges later.
    task automatic expectQuote(input string tag, input logic [SID_W-1:0] sid, input logic [31:0] bid,
                               input logic [31:0] ask, input logic [63:0] res);
        int lat;
        lat = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (quote_bus.o_quote_valid) begin
                lat = k;
                break;
            end
        end
        checkOutput({tag, "_latency"}, 64'(lat), 64'(LATENCY));
        checkOutput({tag, "_sid"}, 64'(quote_bus.o_stock_id), 64'(sid));
        checkOutput({tag, "_bid"}, 64'(quote_bus.o_bid_price), 64'(bid));
        checkOutput({tag, "_ask"}, 64'(quote_bus.o_ask_price), 64'(ask));
        checkOutput({tag, "_res"}, quote_bus.o_reservation, res);
        @(negedge clk);
        checkOutput({tag, "_pulse"}, 64'(quote_bus.o_quote_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] exp_bid [8];
        logic [31:0] exp_ask [8];
        logic [63:0] exp_res [8];
        int idx, first_cyc, last_cyc, seen;

        exp_bid = '{32'd98, 32'd104, 32'd88, 32'd78, 32'd98, 32'd104, 32'd88, 32'd78};
        exp_ask = '{32'd102, 32'd108, 32'd92, 32'd82, 32'd102, 32'd108, 32'd92, 32'd82};
        exp_res = '{64'h64_0000_0000, 64'h6A_0000_0000, 64'h5A_0000_0000, 64'h50_0000_0000,
                    64'h64_0000_0000, 64'h6A_0000_0000, 64'h5A_0000_0000, 64'h50_0000_0000};

        reset_n                = 1'b0;
        inv_wr_en              = 1'b0;
        inv_wr_stock           = '0;
        inv_wr_value           = '0;
        quote_bus.i_data_valid = 1'b0;
        quote_bus.i_stock_id   = '0;
        quote_bus.i_curr_price = '0;
        quote_bus.i_volatility = '0;
        setParams(Q_0_5, Q_1, Q_2);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        checkOutput("reset_valid", 64'(quote_bus.o_quote_valid), 64'd0);
        checkOutput("reset_bid", 64'(quote_bus.o_bid_price), 64'd0);
        checkOutput("reset_ask", 64'(quote_bus.o_ask_price), 64'd0);
        checkOutput("reset_res", quote_bus.o_reservation, 64'd0);
        checkOutput("reset_sid", 64'(quote_bus.o_stock_id), 64'd0);

        applyStimulus(2'd0, 32'd100, Q_4);
        expectQuote("nominal", 2'd0, 32'd98, 32'd102, 64'h64_0000_0000);

        writeInventory(2'd1, 32'sd3);
        applyStimulus(2'd1, 32'd100, Q_4);
        expectQuote("skew_pos", 2'd1, 32'd92, 32'd96, 64'h5E_0000_0000);

        writeInventory(2'd1, -32'sd3);
        applyStimulus(2'd1, 32'd100, Q_4);
        expectQuote("skew_neg", 2'd1, 32'd104, 32'd108, 64'h6A_0000_0000);

        setParams(Q_1, Q_1, Q_0_25);
        applyStimulus(2'd0, 32'd100, Q_0_5);
        expectQuote("rounding", 2'd0, 32'd99, 32'd101, 64'h64_0000_0000);

        setParams(Q_0_5, Q_1, 64'd0);
        applyStimulus(2'd0, 32'd100, 64'd0);
        expectQuote("zero_spread", 2'd0, 32'd100, 32'd101, 64'h64_0000_0000);

        setParams(Q_0_5, Q_1, Q_2);
        writeInventory(2'd3, 32'sd10);
        applyStimulus(2'd3, 32'd1, Q_4);
        expectQuote("clamp_low", 2'd3, 32'd0, 32'd1, 64'hFFFF_FFED_0000_0000);

        // Inventory now: s0=0, s1=-3, s2=0 (overwritten to 5 by the bypassed write), s3=10.
        idx       = 0;
        first_cyc = -1;
        last_cyc  = -1;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    quote_bus.i_data_valid = 1'b1;
                    quote_bus.i_stock_id   = SID_W'(i % 4);
                    quote_bus.i_curr_price = 32'd100;
                    quote_bus.i_volatility = Q_4;
                    inv_wr_en              = (i == 2);
                    inv_wr_stock           = 2'd2;
                    inv_wr_value           = 32'sd5;
                end
                @(negedge clk);
                quote_bus.i_data_valid = 1'b0;
                inv_wr_en              = 1'b0;
            end
            begin
                for (int c = 0; c < 30; c++) begin
                    @(negedge clk);
                    if (quote_bus.o_quote_valid) begin
                        if (idx < 8) begin
                            checkOutput($sformatf("stream%0d_sid", idx), 64'(quote_bus.o_stock_id), 64'(idx % 4));
                            checkOutput($sformatf("stream%0d_bid", idx), 64'(quote_bus.o_bid_price), 64'(exp_bid[idx]));
                            checkOutput($sformatf("stream%0d_ask", idx), 64'(quote_bus.o_ask_price), 64'(exp_ask[idx]));
                            checkOutput($sformatf("stream%0d_res", idx), quote_bus.o_reservation, exp_res[idx]);
                        end
                        if (first_cyc < 0) first_cyc = c;
                        last_cyc = c;
                        idx++;
                    end
                end
            end
        join
        checkOutput("stream_count", 64'(idx), 64'd8);
        checkOutput("stream_span", 64'(last_cyc - first_cyc), 64'd7);

        // Three samples in flight, reset sampled before the first can emerge.
        @(negedge clk);
        quote_bus.i_data_valid = 1'b1;
        quote_bus.i_curr_price = 32'd100;
        quote_bus.i_volatility = Q_4;
        for (int i = 0; i < 3; i++) begin
            quote_bus.i_stock_id = SID_W'(i);
            @(negedge clk);
        end
        quote_bus.i_data_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (quote_bus.o_quote_valid) seen++;
        end
        checkOutput("midflight_no_quote", 64'(seen), 64'd0);
        checkOutput("midflight_bid", 64'(quote_bus.o_bid_price), 64'd0);
        checkOutput("midflight_ask", 64'(quote_bus.o_ask_price), 64'd0);
        checkOutput("midflight_res", quote_bus.o_reservation, 64'd0);
        checkOutput("midflight_sid", 64'(quote_bus.o_stock_id), 64'd0);

        applyStimulus(2'd3, 32'd100, Q_4);
        expectQuote("inv_cleared", 2'd3, 32'd98, 32'd102, 64'h64_0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/as_quote_pipeline.md
Name: as_quote_pipeline

Overview:
- Downstream consumer of the per-stock volatility stage; turns {volatility^2, mid price, stock id} into Avellaneda-Stoikov bid/ask quotes.
- Holds a per-stock inventory register file, written by the position-tracking logic.
- Fully pipelined: one quote per cycle, fixed 5-cycle latency, no backpressure.

Parameters:
- DATA_WIDTH, 32, integer price/inventory width.
- FP_WORD_SIZE, 64, fixed-point word width (Q32.32, unsigned unless stated).
- NUM_STOCKS, 4, number of stocks / inventory entries.
- LATENCY, 5, pipeline depth. Fixed constant, not overridable.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  synchronous active-low reset.
- i_data_valid  in  1  qualifies i_volatility, i_curr_price, i_stock_id.
- i_volatility  in  64  sigma^2, Q32.32.
- i_curr_price  in  32  mid price, unsigned integer.
- i_stock_id  in  $clog2(NUM_STOCKS)  stock of current sample.
- i_gamma  in  64  risk aversion, Q32.32, quasi-static.
- i_time_remaining  in  64  (T-t), Q32.32, quasi-static.
- i_spread_const  in  64  precomputed (2/gamma)ln(1+gamma/k), Q32.32.
- i_inv_wr_en  in  1  inventory write strobe.
- i_inv_wr_stock  in  $clog2(NUM_STOCKS)  inventory entry to write.
- i_inv_wr_value  in  32  signed inventory, two's complement.
- o_quote_valid  out  1  quote valid, one pulse per accepted sample.
- o_stock_id  out  $clog2(NUM_STOCKS)  stock of quote.
- o_bid_price  out  32  bid quote, unsigned integer.
- o_ask_price  out  32  ask quote, unsigned integer.
- o_reservation  out  64  reservation price, signed Q32.32, saturated.

Behaviour:
- Reset (sync, active-low):
  - All pipeline valid bits and o_quote_valid go to 0.
  - o_bid_price, o_ask_price, o_reservation and o_stock_id go to 0.
  - All inventory entries go to 0.
  - Samples in flight when reset asserts are discarded. No o_quote_valid is produced for them.
- Inventory file:
  - Write takes effect on the clock edge when i_inv_wr_en=1.
  - Write-through bypass: if i_inv_wr_en and i_data_valid in the same cycle with i_inv_wr_stock==i_stock_id, S1 captures i_inv_wr_value.
- Data-path stages (the valid bit travels with the data):
  - S1: register price, sigma^2, stock id, inventory q and the quasi-static inputs.
  - S2: a = gamma*sigma^2. The 128-bit product is Q64.64; the result is bits [95:32]. If bits [127:96] are nonzero, saturate to all-ones.
  - S3: risk = a*(T-t), using the same width/saturation rule.
  - S4:
    - skew = q*risk: signed 32 x unsigned 64, signed Q.32 result.
    - half = (risk + i_spread_const)>>1, using a 65-bit add (no overflow loss).
  - S5:
    - r = {price,32'b0} - skew, computed with ≥98-bit signed width.
    - bid_fp = r - half; ask_fp = r + half.
    - bid = floor(bid_fp) (arithmetic >>32). ask = ceil(ask_fp).
    - Clamp both to [0, 2^32-1]. Then enforce ask ≥ 1.
    - If bid ≥ ask: set ask = bid+1. If bid == 2^32-1: set bid = ask-1 instead.
    - o_reservation = r saturated to signed 64-bit.
- Latency: sample accepted at edge N → o_quote_valid=1 after edge N+5, for one cycle.
- Outputs hold their last values while o_quote_valid=0.
- Back-to-back valid samples yield back-to-back quotes; stock ids may interleave arbitrarily.
- i_gamma, i_time_remaining and i_spread_const are sampled in S1 only. Mid-stream changes affect only later samples.

Decomposition:
- Package as_quote_pkg:
  - Q32.32 typedef, FRAC_BITS=32, LATENCY=5.
  - Saturating Q32.32 unsigned multiply function.
  - Signed clamp-to-unsigned-32 function.
- Sub-module as_inventory_regfile: NUM_STOCKS x 32 signed, synchronous write, asynchronous read, write-through bypass.

Test Plan:
- Nominal: price=100, sigma^2=4.0, gamma=0.5, tau=1.0, spread_const=2.0, q=0 → 5 cycles later: bid=98, ask=102, reservation=100.0.
- Inventory skew: same inputs, write q=3 → bid=92, ask=96. Write q=-3 → bid=104, ask=108.
- Rounding: gamma=1.0, sigma^2=0.5, tau=1.0, spread_const=0.25, q=0, price=100 → bid=99, ask=101.
- Zero spread / clamp:
  - sigma^2=0, spread_const=0, price=100 → bid=100, ask=101.
  - price=1, q=10, inputs as in Nominal → bid=0, ask=1.
- Bypass and interleave: same-cycle inventory write q=5 and sample for stock 2; alternate stocks 0-3 every cycle → each quote uses the correct per-stock q; q=5 is applied to the first sample for stock 2.
- Reset mid-flight: issue 3 valid samples, assert i_reset_n=0 for 1 cycle two cycles later → no o_quote_valid for those samples; all outputs and inventory read 0.
